debug_host_link: RTL and testbench



---
 rtl/debug_host_link.sv | 163 ++++++++++++++++
 tb/tb_debug_host_link.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/debug_host_link.sv
// debug_host_link: UART debug-link initiator, sends one command byte and assembles a RESP_BYTES reply (DEBUG_HOST_CHECKSUM_EN adds an XOR check byte)
module debug_host_link #(
  parameter int RESP_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic [7:0]              cmd,
  output logic [7:0]              tx_dato_in,
  output logic                    tx_start,
  input  logic                    tx_done,
  input  logic [7:0]              rx_dato_out,
  input  logic                    rx_done,
  output logic [8*RESP_BYTES-1:0] resp_data,
  output logic                    resp_valid,
  output logic                    busy,
`ifdef DEBUG_HOST_CHECKSUM_EN
  output logic                    chk_err,
`endif
  output logic                    timeout_err
);
`ifdef DEBUG_HOST_CHECKSUM_EN
  localparam int NB = RESP_BYTES + 1;
`else
  localparam int NB = RESP_BYTES;
`endif
  localparam int IW = $clog2(NB + 1);
  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, RECV, DONE, ERR} state_t;
  state_t                  state_q, state_d;
  logic [7:0]              cmd_q, cmd_d;
  logic                    tx_start_q, tx_start_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [TO_W-1:0]         cnt_q, cnt_d;
  logic [8*RESP_BYTES-1:0] shadow_q, shadow_d;
  logic [8*RESP_BYTES-1:0] resp_q, resp_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    busy_q, busy_d;
  logic                    to_err_q, to_err_d;
  logic                    expire, last;
`ifdef DEBUG_HOST_CHECKSUM_EN
  logic [7:0]              xor_q, xor_d;
  logic                    chk_err_q, chk_err_d;
  assign chk_err = chk_err_q;
`endif
  assign tx_dato_in  = cmd_q;
  assign tx_start    = tx_start_q;
  assign resp_data   = resp_q;
  assign resp_valid  = resp_valid_q;
  assign busy        = busy_q;
  assign timeout_err = to_err_q;
  assign expire      = cnt_q == TO_W'(TIMEOUT_CYCLES - 1);
  assign last        = idx_q == IW'(NB - 1);
  // State and output registers; reset aborts any transaction without pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      tx_start_q   <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      to_err_q     <= 1'b0;
`ifdef DEBUG_HOST_CHECKSUM_EN
      xor_q        <= '0;
      chk_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      tx_start_q   <= tx_start_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      to_err_q     <= to_err_d;
`ifdef DEBUG_HOST_CHECKSUM_EN
      xor_q        <= xor_d;
      chk_err_q    <= chk_err_d;
`endif
    end
  end
  // Next state; pulses are registered on the transition so they line up with the new state
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    tx_start_d   = 1'b0;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    resp_d       = resp_q;
    resp_valid_d = 1'b0;
    busy_d       = busy_q;
    to_err_d     = 1'b0;
`ifdef DEBUG_HOST_CHECKSUM_EN
    xor_d        = xor_q;
    chk_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: if (req) begin
        cmd_d   = cmd;
        busy_d  = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        tx_start_d = 1'b1;
        cnt_d      = '0;
        idx_d      = '0;
`ifdef DEBUG_HOST_CHECKSUM_EN
        xor_d      = '0;
`endif
        state_d    = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done) begin
          cnt_d   = '0;
          state_d = RECV;
        end else if (expire) begin
          to_err_d = 1'b1;
          state_d  = ERR;
        end else cnt_d = cnt_q + TO_W'(1);
      end
      RECV: begin
        if (rx_done) begin
          cnt_d = '0;
          idx_d = idx_q + IW'(1);
          for (int i = 0; i < RESP_BYTES; i++)
            if (idx_q == IW'(i)) shadow_d[8*i +: 8] = rx_dato_out;
`ifdef DEBUG_HOST_CHECKSUM_EN
          xor_d = xor_q ^ rx_dato_out;
`endif
          if (last) begin
            resp_valid_d = 1'b1;
            resp_d       = shadow_d;
            state_d      = DONE;
`ifdef DEBUG_HOST_CHECKSUM_EN
            if (xor_d != 8'h00) begin
              resp_valid_d = 1'b0;
              resp_d       = resp_q;
              chk_err_d    = 1'b1;
              state_d      = ERR;
            end
`endif
          end
        end else if (expire) begin
          to_err_d = 1'b1;
          state_d  = ERR;
        end else cnt_d = cnt_q + TO_W'(1);
      end
      default: begin
        busy_d  = 1'b0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_debug_host_link.sv
// tb_debug_host_link: randomized transactions against a transaction-level reference model
module tb_debug_host_link;
  localparam int RB = 2;
  localparam int T  = 100;
  localparam int TW = 7;
`ifdef DEBUG_HOST_CHECKSUM_EN
  localparam int NB = RB + 1;
  localparam int NMODES = 3;
`else
  localparam int NB = RB;
  localparam int NMODES = 2;
`endif
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, tx_done = 1'b0, rx_done = 1'b0;
  logic [7:0] cmd = '0, rx_dato_out = '0, tx_dato_in;
  logic tx_start, resp_valid, busy, timeout_err;
  logic [8*RB-1:0] resp_data, exp_resp = '0;
  int total = 0, bad = 0;
  int n_txs = 0, n_rv = 0, n_to = 0, exp_txs = 0, exp_rv = 0, exp_to = 0;
`ifdef DEBUG_HOST_CHECKSUM_EN
  logic chk_err;
  int n_ce = 0, exp_ce = 0;
`endif
  debug_host_link #(.RESP_BYTES(RB), .TIMEOUT_CYCLES(T), .TO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd),
    .tx_dato_in(tx_dato_in), .tx_start(tx_start), .tx_done(tx_done),
    .rx_dato_out(rx_dato_out), .rx_done(rx_done),
    .resp_data(resp_data), .resp_valid(resp_valid), .busy(busy),
`ifdef DEBUG_HOST_CHECKSUM_EN
    .chk_err(chk_err),
`endif
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    if (tx_start) n_txs++;
    if (resp_valid) n_rv++;
    if (timeout_err) n_to++;
`ifdef DEBUG_HOST_CHECKSUM_EN
    if (chk_err) n_ce++;
`endif
  endtask
  task automatic pulse_rx(input logic [7:0] b);
    rx_dato_out = b;
    rx_done = 1'b1;
    cyc();
    rx_done = 1'b0;
  endtask
  task automatic wait_err();
    int k = 0;
    while (!timeout_err && k < T + 20) begin
      cyc();
      k++;
    end
    check("to_latency", k, T);
    check("to_err", timeout_err, 1);
    exp_to++;
    cyc();
    check("to_pulse", timeout_err, 0);
    check("to_busy_off", busy, 0);
    check("to_resp_keep", resp_data, exp_resp);
  endtask
  // mode 0 success, 1 no tx_done, 2 silence after nb bytes, 3 bad checksum
  task automatic txn(input int mode, input int nb, input bit dir, input logic [31:0] fixed);
    logic [7:0] c, b, x;
    logic [8*RB-1:0] acc;
    int n;
    c = dir ? 8'hA5 : 8'($urandom);
    x = '0;
    acc = '0;
    if (!dir && $urandom_range(1) == 1) pulse_rx(8'($urandom));
    cmd = c;
    req = 1'b1;
    cyc();
    req = 1'b0;
    cmd = ~c;
    check("busy_on", busy, 1);
    check("start_early", tx_start, 0);
    cyc();
    exp_txs++;
    check("tx_start", tx_start, 1);
    check("tx_dato", tx_dato_in, c);
    if (mode == 1) begin
      wait_err();
      return;
    end
    repeat ($urandom_range(4)) begin
      rx_done = 1'($urandom);
      rx_dato_out = 8'($urandom);
      cyc();
    end
    rx_done = 1'b0;
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    check("dato_hold", tx_dato_in, c);
    n = (mode == 2) ? nb : NB;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(6)) begin
        req = 1'($urandom);
        cyc();
      end
      req = 1'b0;
      if (i < RB) begin
        b = dir ? fixed[8*i +: 8] : 8'($urandom);
        acc[8*i +: 8] = b;
        x ^= b;
      end else b = (mode == 3) ? x ^ (8'd1 << $urandom_range(7)) : x;
      pulse_rx(b);
    end
    if (mode == 0) begin
      check("resp_valid", resp_valid, 1);
      check("resp_data", resp_data, acc);
      exp_resp = acc;
      exp_rv++;
      cyc();
      check("rv_pulse", resp_valid, 0);
      check("busy_off", busy, 0);
    end else if (mode == 2) wait_err();
`ifdef DEBUG_HOST_CHECKSUM_EN
    else begin
      check("chk_err", chk_err, 1);
      check("chk_no_to", timeout_err, 0);
      exp_ce++;
      cyc();
      check("chk_busy_off", busy, 0);
      check("chk_resp_keep", resp_data, exp_resp);
    end
`endif
  endtask
  initial begin
    int m;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_pulses", {tx_start, resp_valid, timeout_err}, 0);
    check("rst_dato", tx_dato_in, 0);
    check("rst_resp", resp_data, 0);
    rst_n = 1'b1;
    cyc();
    txn(0, 0, 1'b1, 32'h013C);
    check("resp_013C", resp_data, 16'h013C);
    txn(1, 0, 1'b0, 32'h0);
    txn(2, 1, 1'b1, 32'h0);
    txn(0, 0, 1'b1, 32'h2211);
    check("resp_2211", resp_data, 16'h2211);
`ifdef DEBUG_HOST_CHECKSUM_EN
    txn(3, 0, 1'b1, 32'h013C);
`endif
    cmd = 8'h5A;
    req = 1'b1;
    cyc();
    req = 1'b0;
    cyc();
    exp_txs++;
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    pulse_rx(8'h77);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_resp", resp_data, 0);
    check("mid_rst_dato", tx_dato_in, 0);
    exp_resp = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    repeat (40) begin
      m = $urandom_range(NMODES);
      txn(m, $urandom_range(NB - 1), 1'b0, 32'h0);
    end
    repeat (3) cyc();
    check("n_tx_start", n_txs, exp_txs);
    check("n_resp_valid", n_rv, exp_rv);
    check("n_timeout", n_to, exp_to);
`ifdef DEBUG_HOST_CHECKSUM_EN
    check("n_chk_err", n_ce, exp_ce);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
